seq_adder_arbiter: RTL and testbench

Shares one byte-serial 32-bit sequential adder between NUM_REQ requesters. It arbitrates round-robin, latches the winner's operands and pulses the adder's start. It then waits for the adder's ready, bounded by a watchdog, and returns the sum and overflow to the winner with a one-cycle done pulse. It sits between the requesting units and the sequential_adder instance.

---
 rtl/seq_adder_arbiter_pkg.sv | 20 ++
 rtl/seq_adder_arbiter_if.sv | 35 +++
 rtl/seq_adder_arbiter_rr_arbiter.sv | 31 +++
 rtl/seq_adder_arbiter.sv | 135 +++++++++++++
 tb/tb_seq_adder_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_adder_arbiter_pkg.sv
// Shared types and constants for the sequential-adder arbiter.
package seq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 64;

  // Lowest bit of requester idx's operand slice in the packed a_in/b_in buses.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/seq_adder_arbiter_if.sv
// Requester-side and adder-side signals of the shared adder arbiter.
interface seq_adder_arbiter_if
  import seq_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         res_out;
  logic                     ovf_out;
  logic                     err_out;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_start;
  logic [WIDTH-1:0]         add_res;
  logic                     add_overflow;
  logic                     add_ready;

  // Arbiter side.
  modport slave (
    input  req, a_in, b_in, add_res, add_overflow, add_ready,
    output done, gnt, res_out, ovf_out, err_out, add_a, add_b, add_start
  );

  // Environment side: requesters plus the adder.
  modport master (
    output req, a_in, b_in, add_res, add_overflow, add_ready,
    input  done, gnt, res_out, ovf_out, err_out, add_a, add_b, add_start
  );

endinterface

// File: rtl/seq_adder_arbiter_rr_arbiter.sv
// Combinational round-robin winner selection: first set request bit at or
// above the pointer, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic found;
  int   idx;

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    any    = |req;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_adder_arbiter.sv
// Shares one sequential adder between NUM_REQ requesters: round-robin grant,
// operand latch, start pulse, watchdog-bounded wait, one-cycle done pulse.
module seq_adder_arbiter
  import seq_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  seq_adder_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state, next_state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   arb_win;
  logic               arb_any;
  logic [TMR_W-1:0]   timer;
  logic               timer_exp;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH-1:0]   res;
  logic               ovf;
  logic               err;
  logic [NUM_REQ-1:0] done_v, gnt_v;
  logic               start_v;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (arb_win),
    .any    (arb_any)
  );

  assign timer_exp = (timer == TMR_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; ready is only honoured in WAIT, so a stale or early
  // ready during ISSUE cannot complete an operation.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (arb_any) next_state = ISSUE;
      ISSUE: next_state = WAIT;
      WAIT:  if (bus.add_ready || timer_exp) next_state = RESP;
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand latch, watchdog timer, result capture and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      win   <= '0;
      timer <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            win  <= arb_win;
            op_a <= bus.a_in[slice_lo(int'(arb_win), WIDTH) +: WIDTH];
            op_b <= bus.b_in[slice_lo(int'(arb_win), WIDTH) +: WIDTH];
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (bus.add_ready) begin
            res <= bus.add_res;
            ovf <= bus.add_overflow;
            err <= 1'b0;
          end else if (timer_exp) begin
            res <= '0;
            ovf <= 1'b0;
            err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          // The just-served requester drops to lowest priority.
          if (win == IDX_W'(NUM_REQ - 1)) ptr <= '0;
          else                            ptr <= win + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state and the registered winner.
  always_comb begin
    done_v  = '0;
    gnt_v   = '0;
    start_v = 1'b0;
    case (state)
      ISSUE: begin
        gnt_v[win] = 1'b1;
        start_v    = 1'b1;
      end
      WAIT:  gnt_v[win] = 1'b1;
      RESP: begin
        gnt_v[win]  = 1'b1;
        done_v[win] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done      = done_v;
  assign bus.gnt       = gnt_v;
  assign bus.add_start = start_v;
  assign bus.add_a     = op_a;
  assign bus.add_b     = op_b;
  assign bus.res_out   = res;
  assign bus.ovf_out   = ovf;
  assign bus.err_out   = err;

endmodule

// File: tb/tb_seq_adder_arbiter.sv
// Self-checking bench for seq_adder_arbiter with a behavioural adder and a
// round-robin reference model.
module tb_seq_adder_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ptr   = 0;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  seq_adder_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  seq_adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural sequential adder: ready pulses lat cycles after start.
  int        lat   = 5;
  bit        never = 1'b0;
  logic      busy;
  int        cnt;
  logic [W:0] sum;

  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (bus.add_start) begin
      busy <= 1'b1;
      cnt  <= lat - 1;
      sum  <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
    end else if (busy) begin
      if (cnt == 0) busy <= 1'b0;
      else          cnt  <= cnt - 1;
    end
  end

  assign bus.add_ready    = busy && (cnt == 0) && !never;
  assign bus.add_res      = sum[W-1:0];
  assign bus.add_overflow = sum[W];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Grant and done must never have more than one bit set.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("gnt_onehot", 64'($countones(bus.gnt) <= 1), 64'd1);
      check("done_onehot", 64'($countones(bus.done) <= 1), 64'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_ops();
    for (int i = 0; i < N; i++) begin
      bus.a_in[i*W +: W] = opa[i];
      bus.b_in[i*W +: W] = opb[i];
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One operation starting in an IDLE cycle; returns in the following IDLE cycle.
  task automatic run_op(input logic [N-1:0] r, input int k, input bit tmo, input int drop);
    int         w, c0, n;
    logic [W:0] exp;
    lat     = k;
    never   = tmo;
    bus.req = r;
    apply_ops();
    w   = pick(r);
    exp = {1'b0, opa[w]} + {1'b0, opb[w]};
    c0  = cyc;
    step();
    check("start", 64'(bus.add_start), 64'd1);
    check("gnt", 64'(bus.gnt), 64'(1 << w));
    if (drop >= 0) begin
      step();
      bus.req[drop] = 1'b0;
      for (int i = 0; i < N; i++) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
      end
      apply_ops();
    end
    n = 0;
    while (bus.done == '0 && n < TO + 20) begin
      step();
      n++;
    end
    check("done", 64'(bus.done), 64'(1 << w));
    check("latency", 64'(cyc - c0), tmo ? 64'(TO + 2) : 64'(k + 2));
    check("res", 64'(bus.res_out), tmo ? 64'd0 : 64'(exp[W-1:0]));
    check("ovf", 64'(bus.ovf_out), tmo ? 64'd0 : 64'(exp[W]));
    check("err", 64'(bus.err_out), tmo ? 64'd1 : 64'd0);
    ptr = (w + 1) % N;
    step();
    check("done_pulse", 64'(bus.done), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    step();
    step();
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_start", 64'(bus.add_start), 64'd0);
    check("rst_res", 64'(bus.res_out), 64'd0);
    check("rst_ovf", 64'(bus.ovf_out), 64'd0);
    check("rst_err", 64'(bus.err_out), 64'd0);
    check("rst_add_a", 64'(bus.add_a), 64'd0);
    check("rst_add_b", 64'(bus.add_b), 64'd0);
    rst = 1'b0;
    step();

    // Contention: all four held high, expected order 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < N; i++) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
      end
      run_op(4'b1111, 2 + j, 1'b0, -1);
    end

    // Single request, fixed latency 5.
    opa[0] = 32'h0000_0005;
    opb[0] = 32'h0000_0007;
    run_op(4'b0001, 5, 1'b0, -1);

    // Carry-out on requester 2.
    opa[2] = 32'hFFFF_FFFF;
    opb[2] = 32'h0000_0001;
    run_op(4'b0100, 3, 1'b0, -1);

    // Adder never answers, then a normal operation.
    run_op(4'b0010, 1, 1'b1, -1);
    run_op(4'b1000, 4, 1'b0, -1);

    // Requester 1 withdraws in WAIT; pointer must then sit at 2.
    opa[1] = 32'h1234_5678;
    opb[1] = 32'h0101_0101;
    run_op(4'b0010, 6, 1'b0, 1);
    run_op(4'b1111, 2, 1'b0, -1);

    // Reset during WAIT abandons the operation without a done pulse.
    lat     = 30;
    never   = 1'b0;
    bus.req = 4'b1000;
    step();
    step();
    step();
    rst     = 1'b1;
    bus.req = '0;
    step();
    check("mid_rst_gnt", 64'(bus.gnt), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_start", 64'(bus.add_start), 64'd0);
    check("mid_rst_add_a", 64'(bus.add_a), 64'd0);
    rst = 1'b0;
    ptr = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst_quiet", 64'(bus.done), 64'd0);
    end
    run_op(4'b1001, 3, 1'b0, -1);
    run_op(4'b0010, 2, 1'b0, -1);

    // Randomized traffic.
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < N; i++) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
      end
      run_op(4'($urandom_range(1, 15)), int'($urandom_range(1, 10)), 1'b0, -1);
    end

    bus.req = '0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
